// File: rtl/nvram_uploader.sv
// Serves HPS upload reads of the CMOS/high-score nibble RAM and tracks whether CMOS changed since the last full save.
// Optional restore (download-to-CMOS write) path compiled in with `define NVRAM_UPLOADER_RESTORE_EN.
module nvram_uploader #(
  parameter logic [15:0] NVRAM_INDEX = 16'd4,
  parameter int          CMOS_AW     = 10
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_upload,
  input  logic               ioctl_download,
  input  logic               ioctl_rd,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic [15:0]        ioctl_index,
  output logic [7:0]         ioctl_din,
  output logic               cmos_req,
  input  logic               cmos_gnt,
  output logic [CMOS_AW-1:0] cmos_addr,
  output logic               cmos_we,
  output logic [3:0]         cmos_wdata,
  input  logic [3:0]         cmos_rdata,
  input  logic               cpu_cmos_we,
  output logic               busy,
  output logic               dirty,
  output logic [1:0]         state_dbg
);

  // Handshake: cmos_req rises with a latched address/we and is held until the
  // cycle cmos_gnt is sampled high; it drops the following cycle. Reads see
  // cmos_rdata one cycle after the grant.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic [24:0] LAST_ADDR = 25'(2**CMOS_AW - 1);

  state_e             state_q, state_d;
  logic               cmos_req_q, cmos_req_d;
  logic               cmos_we_q, cmos_we_d;
  logic [CMOS_AW-1:0] cmos_addr_q, cmos_addr_d;
  logic [3:0]         cmos_wdata_q, cmos_wdata_d;
  logic [7:0]         ioctl_din_q, ioctl_din_d;
  logic               busy_q, busy_d;
  logic               dirty_q, dirty_d;
  logic               last_seen_q, last_seen_d;
  logic               upload_q, upload_d;
  logic               download_q, download_d;

  logic index_hit, addr_in_range, idle;
  logic rd_hit, rd_accept, rd_oor, wr_accept;
  logic restore_active, upload_rise, upload_fall, download_fall;
  logic dirty_set, dirty_clr;
  logic unused_restore;

  assign index_hit     = (ioctl_index == NVRAM_INDEX);
  assign addr_in_range = (ioctl_addr <= LAST_ADDR);
  assign idle          = (state_q == S_IDLE);
  assign rd_hit        = idle && ioctl_rd && ioctl_upload && index_hit;
  assign rd_accept     = rd_hit && addr_in_range;
  assign rd_oor        = rd_hit && !addr_in_range;
  assign upload_rise   = !upload_q && ioctl_upload;
  assign upload_fall   = upload_q && !ioctl_upload;

`ifdef NVRAM_UPLOADER_RESTORE_EN
  // A simultaneous rd strobe always wins, so wr is dropped whenever rd is high.
  assign wr_accept      = idle && ioctl_wr && !ioctl_rd && ioctl_download &&
                          index_hit && addr_in_range;
  assign restore_active = ioctl_download && index_hit;
  assign download_fall  = download_q && !ioctl_download && index_hit;
  assign unused_restore = ^ioctl_dout[7:4];
`else
  assign wr_accept      = 1'b0;
  assign restore_active = 1'b0;
  assign download_fall  = 1'b0;
  assign unused_restore = ^{ioctl_wr, ioctl_dout, download_q};
`endif

  assign dirty_set = cpu_cmos_we && !ioctl_upload && !restore_active;
  assign dirty_clr = (upload_fall && last_seen_q) || download_fall;

  always_comb begin
    state_d      = state_q;
    cmos_req_d   = cmos_req_q;
    cmos_we_d    = cmos_we_q;
    cmos_addr_d  = cmos_addr_q;
    cmos_wdata_d = cmos_wdata_q;
    ioctl_din_d  = ioctl_din_q;
    last_seen_d  = last_seen_q;
    dirty_d      = dirty_q;
    upload_d     = ioctl_upload;
    download_d   = ioctl_download;

    case (state_q)
      S_IDLE: begin
        if (rd_accept) begin
          state_d     = S_REQ;
          cmos_req_d  = 1'b1;
          cmos_we_d   = 1'b0;
          cmos_addr_d = ioctl_addr[CMOS_AW-1:0];
        end else if (rd_oor) begin
          ioctl_din_d = 8'hFF;
        end else if (wr_accept) begin
          state_d      = S_REQ;
          cmos_req_d   = 1'b1;
          cmos_we_d    = 1'b1;
          cmos_addr_d  = ioctl_addr[CMOS_AW-1:0];
          cmos_wdata_d = ioctl_dout[3:0];
        end
      end
      S_REQ: begin
        if (cmos_gnt) begin
          cmos_req_d = 1'b0;
          cmos_we_d  = 1'b0;
          // A restore write completes in the granted cycle; only reads need the data slot.
          state_d    = cmos_we_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        ioctl_din_d = {4'hF, cmos_rdata};
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The flag belongs to one upload session, so both session edges reset it.
    if (upload_rise || upload_fall) last_seen_d = 1'b0;
    if (rd_accept && (ioctl_addr == LAST_ADDR)) last_seen_d = 1'b1;

    if (dirty_clr) dirty_d = 1'b0;
    if (dirty_set) dirty_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmos_req_q   <= 1'b0;
      cmos_we_q    <= 1'b0;
      cmos_addr_q  <= '0;
      cmos_wdata_q <= 4'h0;
      ioctl_din_q  <= 8'h00;
      busy_q       <= 1'b0;
      dirty_q      <= 1'b0;
      last_seen_q  <= 1'b0;
      upload_q     <= 1'b0;
      download_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmos_req_q   <= cmos_req_d;
      cmos_we_q    <= cmos_we_d;
      cmos_addr_q  <= cmos_addr_d;
      cmos_wdata_q <= cmos_wdata_d;
      ioctl_din_q  <= ioctl_din_d;
      busy_q       <= busy_d;
      dirty_q      <= dirty_d;
      last_seen_q  <= last_seen_d;
      upload_q     <= upload_d;
      download_q   <= download_d;
    end
  end

  assign ioctl_din  = ioctl_din_q;
  assign cmos_req   = cmos_req_q;
  assign cmos_we    = cmos_we_q;
  assign cmos_addr  = cmos_addr_q;
  assign cmos_wdata = cmos_wdata_q;
  assign busy       = busy_q;
  assign dirty      = dirty_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_nvram_uploader.sv
// Directed bench for nvram_uploader: read latency/stall, range and index filtering,
// restore write (when NVRAM_UPLOADER_RESTORE_EN is defined), dirty tracking and async reset.
module tb_nvram_uploader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload, ioctl_download, ioctl_rd, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] ioctl_index;
  logic [7:0]  ioctl_din;
  logic        cmos_req, cmos_gnt, cmos_we;
  logic [9:0]  cmos_addr;
  logic [3:0]  cmos_wdata, cmos_rdata;
  logic        cpu_cmos_we, busy, dirty;
  logic [1:0]  state_dbg;

  nvram_uploader #(.NVRAM_INDEX(16'd4), .CMOS_AW(10)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_upload   (ioctl_upload),
    .ioctl_download (ioctl_download),
    .ioctl_rd       (ioctl_rd),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_din      (ioctl_din),
    .cmos_req       (cmos_req),
    .cmos_gnt       (cmos_gnt),
    .cmos_addr      (cmos_addr),
    .cmos_we        (cmos_we),
    .cmos_wdata     (cmos_wdata),
    .cmos_rdata     (cmos_rdata),
    .cpu_cmos_we    (cpu_cmos_we),
    .busy           (busy),
    .dirty          (dirty),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int vectors = 0;
  int miscompares = 0;
  int req_cycles = 0;
  int stall_cycles = 0;
  int wr_count = 0;
  int base_req, base_stall, base_wr;
  logic [9:0] wr_addr_seen = '0;
  logic [3:0] wr_data_seen = '0;

  // CMOS-side monitor: what the memory would observe at each edge
  always @(posedge clk_sys) begin
    if (!reset) begin
      if (cmos_req) req_cycles++;
      if (cmos_req && !cmos_gnt) stall_cycles++;
      if (cmos_gnt && cmos_we) begin
        wr_count++;
        wr_addr_seen = cmos_addr;
        wr_data_seen = cmos_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // read with cmos_gnt held high: din is valid on return
  task automatic read_imm(input logic [24:0] a, input logic [3:0] nib);
    cmos_rdata = nib;
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    ioctl_upload = 0; ioctl_download = 0; ioctl_rd = 0; ioctl_wr = 0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_index = 16'd4;
    cmos_gnt = 1'b1; cmos_rdata = 4'h0; cpu_cmos_we = 1'b0;
    tick(); tick();
    chk("rst_req", cmos_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_din", ioctl_din, 8'h00);
    chk("rst_addr", cmos_addr, 0);
    chk("rst_we", cmos_we, 0);
    chk("rst_wdata", cmos_wdata, 0);
    chk("rst_dirty", dirty, 0);
    reset = 1'b0;
    tick();

    // immediate grant read of addr 5
    ioctl_upload = 1'b1;
    tick();
    cmos_rdata = 4'hA; ioctl_addr = 25'd5; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    chk("imm_busy1", busy, 1);
    chk("imm_req1", cmos_req, 1);
    chk("imm_addr", cmos_addr, 5);
    chk("imm_we", cmos_we, 0);
    chk("imm_din1", ioctl_din, 8'h00);
    tick();
    chk("imm_busy2", busy, 1);
    chk("imm_req2", cmos_req, 0);
    chk("imm_din2", ioctl_din, 8'h00);
    tick();
    chk("imm_din3", ioctl_din, 8'hFA);
    chk("imm_busy3", busy, 0);
    tick();
    chk("imm_din_hold", ioctl_din, 8'hFA);

    // out of range read
    base_req = req_cycles;
    ioctl_addr = 25'd1024; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    chk("oor_din", ioctl_din, 8'hFF);
    chk("oor_busy", busy, 0);
    tick();
    chk("oor_noreq", req_cycles - base_req, 0);

    // wrong index, then right index outside its session
    ioctl_index = 16'd0; ioctl_addr = 25'd6; cmos_rdata = 4'h1; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    chk("idx_busy", busy, 0);
    tick(); tick();
    chk("idx_din", ioctl_din, 8'hFF);
    ioctl_index = 16'd4; ioctl_upload = 1'b0;
    tick();
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    chk("nosess_busy", busy, 0);
    tick(); tick();
    chk("nosess_din", ioctl_din, 8'hFF);
    chk("nosess_noreq", req_cycles - base_req, 0);

    // stalled grant, with a strobe arriving while busy
    ioctl_upload = 1'b1; cmos_gnt = 1'b0; cmos_rdata = 4'h3;
    tick();
    base_stall = stall_cycles;
    ioctl_addr = 25'd0; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("stall_req", cmos_req, 1);
      chk("stall_din", ioctl_din, 8'hFF);
      if (i == 5) begin ioctl_addr = 25'd7; ioctl_rd = 1'b1; end
      if (i == 6) begin ioctl_addr = 25'd0; ioctl_rd = 1'b0; end
      tick();
    end
    cmos_gnt = 1'b1;
    tick();
    cmos_gnt = 1'b0;
    chk("stall_req_drop", cmos_req, 0);
    chk("stall_din_gnt", ioctl_din, 8'hFF);
    chk("stall_count", stall_cycles - base_stall, 20);
    tick();
    chk("stall_din", ioctl_din, 8'hF3);
    chk("stall_busy", busy, 0);
    tick();
    chk("stall_noqueue_busy", busy, 0);
    chk("stall_addr", cmos_addr, 0);
    cmos_gnt = 1'b1;

    // rd and wr in the same cycle: rd wins, wr dropped
    ioctl_download = 1'b1;
    tick();
    base_wr = wr_count;
    cmos_rdata = 4'hC; ioctl_addr = 25'd9; ioctl_dout = 8'h05;
    ioctl_rd = 1'b1; ioctl_wr = 1'b1;
    tick();
    ioctl_rd = 1'b0; ioctl_wr = 1'b0;
    chk("both_we", cmos_we, 0);
    tick(); tick();
    chk("both_din", ioctl_din, 8'hFC);
    chk("both_nowr", wr_count - base_wr, 0);
    ioctl_download = 1'b0; ioctl_upload = 1'b0;
    tick();

    // dirty: CPU write during upload ignored, outside sets
    ioctl_upload = 1'b1;
    tick();
    cpu_cmos_we = 1'b1;
    tick();
    cpu_cmos_we = 1'b0;
    chk("dirty_in_upload", dirty, 0);
    ioctl_upload = 1'b0;
    tick();
    cpu_cmos_we = 1'b1;
    tick();
    cpu_cmos_we = 1'b0;
    chk("dirty_set", dirty, 1);

    // partial upload up to 500 keeps dirty
    ioctl_upload = 1'b1;
    tick();
    for (int a = 0; a <= 500; a++) begin
      read_imm(25'(a), 4'(a));
      chk("part_din", ioctl_din, {24'h0, 4'hF, 4'(a)});
    end
    ioctl_upload = 1'b0;
    tick(); tick();
    chk("dirty_partial", dirty, 1);

    // full upload 0..1023 clears dirty
    ioctl_upload = 1'b1;
    tick();
    for (int a = 0; a < 1024; a++) begin
      read_imm(25'(a), 4'(a * 7));
      chk("full_din", ioctl_din, {24'h0, 4'hF, 4'(a * 7)});
    end
    chk("dirty_before_end", dirty, 1);
    ioctl_upload = 1'b0;
    tick();
    chk("dirty_full", dirty, 0);

    // set beats clear in the same cycle
    cpu_cmos_we = 1'b1;
    tick();
    cpu_cmos_we = 1'b0;
    ioctl_upload = 1'b1;
    tick();
    read_imm(25'd1023, 4'h9);
    chk("last_din", ioctl_din, 8'hF9);
    ioctl_upload = 1'b0; cpu_cmos_we = 1'b1;
    tick();
    cpu_cmos_we = 1'b0;
    tick();
    chk("dirty_set_prio", dirty, 1);

    // restore write to 1023
    ioctl_download = 1'b1;
    tick();
    base_wr = wr_count;
    ioctl_addr = 25'd1023; ioctl_dout = 8'h37; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
`ifdef NVRAM_UPLOADER_RESTORE_EN
    chk("rst_wr_busy", busy, 1);
    chk("rst_wr_we", cmos_we, 1);
    chk("rst_wr_addr", cmos_addr, 1023);
    tick();
    chk("rst_wr_done", busy, 0);
    chk("rst_wr_we_off", cmos_we, 0);
    chk("rst_wr_count", wr_count - base_wr, 1);
    chk("rst_wr_addr_seen", wr_addr_seen, 1023);
    chk("rst_wr_data_seen", wr_data_seen, 4'h7);
    ioctl_download = 1'b0;
    tick();
    chk("dirty_dl_clear", dirty, 0);
    ioctl_download = 1'b1;
    tick();
    cpu_cmos_we = 1'b1;
    tick();
    cpu_cmos_we = 1'b0;
    chk("dirty_in_restore", dirty, 0);
    ioctl_download = 1'b0;
    tick();
`else
    chk("nowr_busy", busy, 0);
    chk("nowr_we", cmos_we, 0);
    tick();
    chk("nowr_count", wr_count - base_wr, 0);
    ioctl_download = 1'b0;
    tick();
    chk("dirty_dl_keep", dirty, 1);
`endif

    // reset asserted while waiting in REQ
    ioctl_upload = 1'b1; cmos_gnt = 1'b0;
    tick();
    base_wr = wr_count;
    ioctl_addr = 25'd2; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    chk("mid_req", cmos_req, 1);
    chk("mid_din", ioctl_din, 8'hF9);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_req", cmos_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_din", ioctl_din, 8'h00);
    chk("mid_rst_dirty", dirty, 0);
    tick();
    reset = 1'b0; cmos_gnt = 1'b1;
    tick(); tick(); tick();
    chk("mid_nowr", wr_count - base_wr, 0);
    chk("mid_busy", busy, 0);
    chk("mid_req_after", cmos_req, 0);
    chk("mid_din_after", ioctl_din, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nvram_uploader.md
NVRAM_UPLOADER -- requirements
Module: nvram_uploader

Interface
REQ-001 SHALL have parameter NVRAM_INDEX, default 16'd4, the ioctl_index value selecting the CMOS/high-score image.
REQ-002 SHALL have parameter CMOS_AW, default 10, the CMOS address width (1024 nibbles).
REQ-003 clk_sys  in  1  sole clock; all logic is on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 ioctl_upload  in  1  HPS upload session active.
REQ-006 ioctl_download  in  1  HPS download session active.
REQ-007 ioctl_rd  in  1  one-cycle read strobe, upload byte request.
REQ-008 ioctl_wr  in  1  one-cycle write strobe, download byte.
REQ-009 ioctl_addr  in  25  byte address of the current rd/wr.
REQ-010 ioctl_dout  in  8  download byte.
REQ-011 ioctl_index  in  16  image selector.
REQ-012 ioctl_din  out  8  upload byte returned to HPS.
REQ-013 cmos_req  out  1  request for the CMOS port; held until granted.
REQ-014 cmos_gnt  in  1  CPU-idle slot grant; one cycle.
REQ-015 cmos_addr  out  CMOS_AW  CMOS address.
REQ-016 cmos_we  out  1  CMOS write enable; valid only in a granted cycle.
REQ-017 cmos_wdata  out  4  CMOS write nibble.
REQ-018 cmos_rdata  in  4  CMOS read nibble, valid the cycle after grant.
REQ-019 cpu_cmos_we  in  1  game CPU CMOS write, for dirty tracking.
REQ-020 busy  out  1  high whenever the FSM is not in IDLE.
REQ-021 dirty  out  1  CMOS changed since the last complete upload.

Function
REQ-022 SHALL implement FSM states IDLE, REQ, DATA.
- Accepted read: from IDLE, ioctl_rd && ioctl_upload && ioctl_index==NVRAM_INDEX && ioctl_addr < 2**CMOS_AW. Latch the address, assert cmos_req with cmos_we=0, go to REQ.
- In REQ: wait for cmos_gnt, then go to DATA.
- In DATA: ioctl_din <= {4'hF, cmos_rdata}, then go to IDLE.
REQ-023 SHALL treat an accepted read with ioctl_addr >= 2**CMOS_AW as follows: ioctl_din <= 8'hFF on the next cycle, no CMOS access, FSM stays IDLE.
REQ-024 SHALL deassert cmos_req in the cycle after cmos_gnt is sampled.
REQ-025 With an immediate grant, SHALL have ioctl_din valid 3 cycles after ioctl_rd, and SHALL keep it stable until the next accepted read.
REQ-026 SHALL handle an accepted write (only when RESTORE is compiled in) as follows: ioctl_wr && ioctl_download && index match && addr in range, FSM IDLE. Latch the address and ioctl_dout[3:0], go to REQ, and drive cmos_we=1 in the granted cycle. No DATA state; return to IDLE.
REQ-027 SHALL ignore, and not queue, rd/wr strobes arriving while busy=1, strobes with a non-matching index, and strobes outside their session.
REQ-028 SHALL give rd priority and drop wr when rd and wr are asserted in the same cycle.
REQ-029 SHALL set dirty on cpu_cmos_we when ioctl_upload=0 and no restore is in progress.
REQ-030 SHALL clear dirty on the falling edge of ioctl_upload if byte address 2**CMOS_AW-1 was read during that session.
REQ-031 SHALL clear dirty on the falling edge of ioctl_download for a matching index.
REQ-032 SHALL give set priority over clear when both occur in the same cycle.
REQ-033 SHALL ignore cpu_cmos_we during a session; a CPU write during upload does not set dirty.

Reset
REQ-034 On reset assertion SHALL immediately (asynchronously) force: FSM=IDLE, cmos_req=0, cmos_we=0, busy=0, ioctl_din=8'h00, cmos_addr=0, cmos_wdata=0, dirty=0, last-address-seen flag=0, session edge detectors=0.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction; no CMOS write occurs after reset asserts.

Configuration
REQ-036 Macro NVRAM_UPLOADER_RESTORE_EN SHALL control the write (restore) path.
- Defined: REQ-026 and REQ-031 apply.
- Undefined: ioctl_wr and ioctl_dout are ignored, cmos_we is tied to 0, and dirty is cleared only by upload completion.

Verification
REQ-037 Immediate grant: upload, index 4, ioctl_rd addr 5, cmos_rdata=4'hA, gnt tied 1 -> cmos_addr=5, ioctl_din=8'hFA 3 cycles later, busy high for 2 cycles.
REQ-038 Stalled grant: gnt held low 20 cycles after read of addr 0 -> cmos_req held 20 cycles, ioctl_din unchanged until grant+1, then 8'hF<rdata>.
REQ-039 Out of range and wrong index: read addr 1024 -> ioctl_din=8'hFF, cmos_req never set. Index 0 read -> no response at all.
REQ-040 Restore (macro defined): download index 4, wr addr 1023, dout 8'h37 -> one granted cycle with cmos_we=1, cmos_addr=1023, cmos_wdata=4'h7. Macro undefined -> cmos_we stays 0.
REQ-041 Dirty tracking: cpu_cmos_we pulse -> dirty=1. Full upload reading addrs 0..1023, then upload falls -> dirty=0. Upload ending after addr 500 -> dirty stays 1.
REQ-042 Reset mid-operation: reset asserted in REQ state -> cmos_req=0, busy=0, ioctl_din=8'h00 the same cycle. A later grant causes no write.
